// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register rename tags.
// Holds committed values for x1..x31 plus the ROB nick of the youngest in-flight
// writer of each register. It serves two combinational source lookups that
// return either a ready value (nick 0) or the pending nick, forwarding a commit
// in the same cycle. A misprediction clear drops every pending tag.
`default_nettype none

module regfile_rename #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int NICK_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [4:0]        iROB_nick_regnm,
    input  logic              iRF_en,
    input  logic [4:0]        iRF_rd_regnm,
    input  logic [DATA_W-1:0] iRF_rd_dt,
    input  logic [NICK_W-1:0] iRF_rd_nick,
    input  logic [4:0]        iRS1_regnm,
    input  logic [4:0]        iRS2_regnm,
    output logic [DATA_W-1:0] oRS1_dt,
    output logic [NICK_W-1:0] oRS1_nick,
    output logic [DATA_W-1:0] oRS2_dt,
    output logic [NICK_W-1:0] oRS2_nick
);

    logic [DATA_W-1:0] data_q [REG_NUM];
    logic [DATA_W-1:0] data_d [REG_NUM];
    logic [NICK_W-1:0] tag_q  [REG_NUM];
    logic [NICK_W-1:0] tag_d  [REG_NUM];

    // Source lookup. Sources see the tags as they stood before this cycle's
    // rename, so an instruction never waits on its own destination rename.
    // During a clear every register reads as ready; a commit landing on the
    // same register is forwarded by register number, because the tag it
    // would have matched is being discarded.
    function automatic logic [NICK_W+DATA_W-1:0] lookup(input logic [4:0] r);
        logic [DATA_W-1:0] dt;
        logic [NICK_W-1:0] nk;
        dt = '0;
        nk = '0;
        if (r != 5'd0) begin
            if (iclr) begin
                dt = (iRF_en && iRF_rd_regnm == r) ? iRF_rd_dt : data_q[r];
            end else if (tag_q[r] == '0) begin
                dt = data_q[r];
            end else if (iRF_en && iRF_rd_nick == tag_q[r]) begin
                dt = iRF_rd_dt;
            end else begin
                nk = tag_q[r];
            end
        end
        return {nk, dt};
    endfunction

    // Both lookup ports; outputs are forced to zero while reset is asserted.
    always_comb begin
        if (rst) begin
            {oRS1_nick, oRS1_dt} = '0;
            {oRS2_nick, oRS2_dt} = '0;
        end else begin
            {oRS1_nick, oRS1_dt} = lookup(iRS1_regnm);
            {oRS2_nick, oRS2_dt} = lookup(iRS2_regnm);
        end
    end

    // Next-state: commit data, conditional tag release, rename, then clear.
    // Later assignments win, which encodes the priority of the four updates.
    always_comb begin
        // NOTE: default every array entry to its current value first; any
        // path that leaves an entry unassigned would infer a latch.
        data_d = data_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (iRF_en && iRF_rd_regnm != 5'd0) begin
                data_d[iRF_rd_regnm] = iRF_rd_dt;
                // Only release the tag if no younger writer has replaced it.
                if (tag_q[iRF_rd_regnm] == iRF_rd_nick) begin
                    tag_d[iRF_rd_regnm] = '0;
                end
            end
            if (iROB_nick_en && !iclr && iROB_nick_regnm != 5'd0) begin
                tag_d[iROB_nick_regnm] = iROB_nick;
            end
            if (iclr) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    tag_d[i] = '0;
                end
            end
        end
    end

    // State registers with synchronous reset. x0 is never a write target, so
    // its entries stay at their reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this register file is architectural state that must read
            // as zero after reset, so the storage arrays are reset explicitly
            // rather than left uninitialised like a plain RAM.
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values, independent of statement order.
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_rename.sv
// Directed self-checking bench for regfile_rename: rename, commit bypass,
// stale-commit tag retention, rename-over-release, flush, x0 and rdy hold.
`timescale 1ns/1ps

module tb_regfile_rename;

    logic        clk = 1'b0;
    logic        rst, rdy, iclr;
    logic        iROB_nick_en;
    logic [4:0]  iROB_nick, iROB_nick_regnm;
    logic        iRF_en;
    logic [4:0]  iRF_rd_regnm;
    logic [31:0] iRF_rd_dt;
    logic [4:0]  iRF_rd_nick;
    logic [4:0]  iRS1_regnm, iRS2_regnm;
    logic [31:0] oRS1_dt, oRS2_dt;
    logic [4:0]  oRS1_nick, oRS2_nick;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    regfile_rename #(.REG_NUM(32), .DATA_W(32), .NICK_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .iclr            (iclr),
        .iROB_nick_en    (iROB_nick_en),
        .iROB_nick       (iROB_nick),
        .iROB_nick_regnm (iROB_nick_regnm),
        .iRF_en          (iRF_en),
        .iRF_rd_regnm    (iRF_rd_regnm),
        .iRF_rd_dt       (iRF_rd_dt),
        .iRF_rd_nick     (iRF_rd_nick),
        .iRS1_regnm      (iRS1_regnm),
        .iRS2_regnm      (iRS2_regnm),
        .oRS1_dt         (oRS1_dt),
        .oRS1_nick       (oRS1_nick),
        .oRS2_dt         (oRS2_dt),
        .oRS2_nick       (oRS2_nick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [4:0] r,
                        input logic [31:0] dt, input logic [4:0] nk);
        iRS1_regnm = r;
        #1;
        check({tag, ".rs1_dt"}, oRS1_dt, dt);
        check({tag, ".rs1_nick"}, {27'd0, oRS1_nick}, {27'd0, nk});
    endtask

    task automatic chk2(input string tag, input logic [4:0] r,
                        input logic [31:0] dt, input logic [4:0] nk);
        iRS2_regnm = r;
        #1;
        check({tag, ".rs2_dt"}, oRS2_dt, dt);
        check({tag, ".rs2_nick"}, {27'd0, oRS2_nick}, {27'd0, nk});
    endtask

    task automatic idle();
        iclr = 0; iROB_nick_en = 0; iROB_nick = 0; iROB_nick_regnm = 0;
        iRF_en = 0; iRF_rd_regnm = 0; iRF_rd_dt = 0; iRF_rd_nick = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] r, input logic [4:0] nk);
        iROB_nick_en = 1; iROB_nick_regnm = r; iROB_nick = nk;
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] dt, input logic [4:0] nk);
        iRF_en = 1; iRF_rd_regnm = r; iRF_rd_dt = dt; iRF_rd_nick = nk;
    endtask

    initial begin
        idle();
        rst = 1; rdy = 1; iRS1_regnm = 5; iRS2_regnm = 0;
        tick(); tick();
        chk1("rst_hold", 5'd5, 32'h0, 5'd0);
        rst = 0;

        // 1: reset state
        chk1("reset_x5", 5'd5, 32'h0, 5'd0);
        chk2("reset_x0", 5'd0, 32'h0, 5'd0);

        // 2: rename x3 -> 7, invisible in its own cycle
        rename(5'd3, 5'd7);
        chk1("rename_same_cycle", 5'd3, 32'h0, 5'd0);
        tick(); idle();
        chk1("renamed_x3", 5'd3, 32'h0, 5'd7);
        commit(5'd3, 32'hDEADBEEF, 5'd7);
        chk1("bypass_x3", 5'd3, 32'hDEADBEEF, 5'd0);
        tick(); idle();
        chk1("committed_x3", 5'd3, 32'hDEADBEEF, 5'd0);

        // 3: older commit does not release younger tag
        rename(5'd4, 5'd2); tick();
        rename(5'd4, 5'd9); tick(); idle();
        commit(5'd4, 32'h11, 5'd2);
        chk2("stale_commit_x4", 5'd4, 32'h0, 5'd9);
        tick(); idle();
        chk2("kept_tag_x4", 5'd4, 32'h0, 5'd9);

        // 4: rename overrides same-cycle tag release
        rename(5'd6, 5'd4); tick(); idle();
        commit(5'd6, 32'h55, 5'd4);
        rename(5'd6, 5'd12);
        tick(); idle();
        chk1("rename_wins_x6", 5'd6, 32'h0, 5'd12);

        // 5: flush with commit, rename dropped
        rename(5'd1, 5'd3); tick();
        rename(5'd2, 5'd5); tick();
        rename(5'd8, 5'd6); tick(); idle();
        chk1("pre_clr_x8", 5'd8, 32'h0, 5'd6);
        iclr = 1;
        commit(5'd2, 32'hA5, 5'd5);
        rename(5'd9, 5'd20);
        chk1("clr_bypass_x2", 5'd2, 32'hA5, 5'd0);
        chk2("clr_read_x4", 5'd4, 32'h11, 5'd0);
        tick(); idle();
        chk1("post_clr_x1", 5'd1, 32'h0, 5'd0);
        chk2("post_clr_x2", 5'd2, 32'hA5, 5'd0);
        chk1("post_clr_x8", 5'd8, 32'h0, 5'd0);
        chk2("dropped_rename_x9", 5'd9, 32'h0, 5'd0);
        chk1("post_clr_x6", 5'd6, 32'h55, 5'd0);
        chk2("post_clr_x4", 5'd4, 32'h11, 5'd0);

        // 6: x0 is immutable
        rename(5'd0, 5'd10);
        commit(5'd0, 32'h1234, 5'd10);
        chk1("x0_same_cycle", 5'd0, 32'h0, 5'd0);
        tick(); idle();
        chk1("x0_after", 5'd0, 32'h0, 5'd0);

        // rdy low holds all state
        rdy = 0;
        rename(5'd7, 5'd11);
        commit(5'd6, 32'h99, 5'd0);
        tick(); idle(); rdy = 1;
        chk1("hold_x7", 5'd7, 32'h0, 5'd0);
        chk2("hold_x6", 5'd6, 32'h55, 5'd0);

        // rename with nick 0 clears the tag
        rename(5'd10, 5'd13); tick();
        rename(5'd10, 5'd0); tick(); idle();
        chk1("nick0_clear_x10", 5'd10, 32'h0, 5'd0);

        // reset forces outputs low and clears stored data
        rst = 1;
        chk1("rst_out_x3", 5'd3, 32'h0, 5'd0);
        tick(); rst = 0;
        chk1("rst_clr_x3", 5'd3, 32'h0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
